// File: rtl/readburst_avalon.sv
// Avalon-MM burst read responder for the readburst channel: fetches up to three
// dwords per request and returns the requested bytes aligned so byte 0 is the addressed byte.
module readburst_avalon (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        readburst_do,
  output logic        readburst_done,
  input  logic [31:0] readburst_address,
  input  logic [1:0]  readburst_dword_length,
  input  logic [3:0]  readburst_byte_length,
  output logic [95:0] readburst_data,
  output logic [29:0] avm_address,
  output logic        avm_read,
  output logic [2:0]  avm_burstcount,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RECEIVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [29:0]      addr_q, addr_d;
  logic [1:0]       offset_q, offset_d;
  logic [3:0]       blen_q, blen_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       beat_q, beat_d;
  logic [2:0][31:0] word_q, word_d;
  logic             read_q, read_d;
  logic             done_q, done_d;
  logic [95:0]      data_q, data_d;

  logic             beat_accept_s;
  logic             last_beat_s;
  logic [127:0]     shifted_s;
  logic [95:0]      aligned_s;

  // A beat in the accepting ISSUE cycle counts too, for zero-latency slaves.
  assign beat_accept_s = avm_readdatavalid &&
                         (((state_q == S_ISSUE) && !avm_waitrequest) || (state_q == S_RECEIVE));
  assign last_beat_s   = beat_accept_s && (beat_q == (count_q - 2'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (readburst_do) state_d = S_ISSUE;
        else              state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (!avm_waitrequest) state_d = last_beat_s ? S_DONE : S_RECEIVE;
        else                  state_d = S_ISSUE;
      end
      S_RECEIVE: begin
        if (last_beat_s) state_d = S_DONE;
        else             state_d = S_RECEIVE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request context latch and beat capture
  always_comb begin
    addr_d   = addr_q;
    offset_d = offset_q;
    blen_d   = blen_q;
    count_d  = count_q;
    beat_d   = beat_q;
    word_d   = word_q;
    if ((state_q == S_IDLE) && readburst_do) begin
      addr_d   = readburst_address[31:2];
      offset_d = readburst_address[1:0];
      blen_d   = readburst_byte_length;
      count_d  = (readburst_dword_length == 2'd0) ? 2'd1 : readburst_dword_length;
      beat_d   = 2'd0;
      word_d   = 96'h0;
    end else if (beat_accept_s) begin
      beat_d = beat_q + 2'd1;
      case (beat_q)
        2'd0:    word_d[0] = avm_readdata;
        2'd1:    word_d[1] = avm_readdata;
        2'd2:    word_d[2] = avm_readdata;
        default: word_d    = word_q;
      endcase
    end else begin
      beat_d = beat_q;
    end
  end

  // Byte alignment; the zero top word supplies the fill shifted in by the offset.
  always_comb begin
    shifted_s = {32'h0, word_d} >> {offset_q, 3'b000};
    aligned_s = 96'h0;
    for (int i = 0; i < 12; i++) begin
      if (4'(i) < blen_q) aligned_s[8*i +: 8] = shifted_s[8*i +: 8];
      else                aligned_s[8*i +: 8] = 8'h00;
    end
  end

  // Output logic, computed one cycle ahead so every output is a flop
  always_comb begin
    read_d = (state_d == S_ISSUE);
    done_d = (state_d == S_DONE);
    if (state_d == S_DONE) data_d = aligned_s;
    else                   data_d = data_q;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 30'h0;
      offset_q <= 2'd0;
      blen_q   <= 4'd0;
      count_q  <= 2'd0;
      beat_q   <= 2'd0;
      word_q   <= 96'h0;
      read_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 96'h0;
    end else begin
      addr_q   <= addr_d;
      offset_q <= offset_d;
      blen_q   <= blen_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      word_q   <= word_d;
      read_q   <= read_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_burstcount = {1'b0, count_q};
  assign avm_read       = read_q;
  assign readburst_done = done_q;
  assign readburst_data = data_q;

endmodule

// File: tb/tb_readburst_avalon.sv
// Directed bench for readburst_avalon: inputs change and outputs are checked on the falling edge.
module tb_readburst_avalon;

  logic        clk;
  logic        rst_n;
  logic        readburst_do;
  logic        readburst_done;
  logic [31:0] readburst_address;
  logic [1:0]  readburst_dword_length;
  logic [3:0]  readburst_byte_length;
  logic [95:0] readburst_data;
  logic [29:0] avm_address;
  logic        avm_read;
  logic [2:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int acc0;
  int done0;

  readburst_avalon dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .readburst_do           (readburst_do),
    .readburst_done         (readburst_done),
    .readburst_address      (readburst_address),
    .readburst_dword_length (readburst_dword_length),
    .readburst_byte_length  (readburst_byte_length),
    .readburst_data         (readburst_data),
    .avm_address            (avm_address),
    .avm_read               (avm_read),
    .avm_burstcount         (avm_burstcount),
    .avm_waitrequest        (avm_waitrequest),
    .avm_readdata           (avm_readdata),
    .avm_readdatavalid      (avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted Avalon reads and done pulses, counted at the active edge
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) acc_cnt <= acc_cnt + 1;
    if (readburst_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic request(input logic [31:0] a, input logic [1:0] dl, input logic [3:0] bl);
    readburst_do           = 1'b1;
    readburst_address      = a;
    readburst_dword_length = dl;
    readburst_byte_length  = bl;
  endtask

  initial begin
    rst_n = 1'b0;
    readburst_do = 1'b0;
    readburst_address = 32'h0;
    readburst_dword_length = 2'd0;
    readburst_byte_length = 4'd0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0;
    avm_readdatavalid = 1'b0;
    tick();
    tick();
    chk("rst_done", readburst_done, 96'h0);
    chk("rst_read", avm_read, 96'h0);
    chk("rst_addr", avm_address, 96'h0);
    chk("rst_bc", avm_burstcount, 96'h0);
    chk("rst_data", readburst_data, 96'h0);
    rst_n = 1'b1;
    tick();

    // Aligned single read, zero wait, zero latency
    request(32'h1000, 2'd1, 4'd4);
    tick();
    chk("t1_read", avm_read, 96'h1);
    chk("t1_addr", avm_address, 96'h400);
    chk("t1_bc", avm_burstcount, 96'h1);
    chk("t1_done_early", readburst_done, 96'h0);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDDCCBBAA;
    tick();
    chk("t1_done", readburst_done, 96'h1);
    chk("t1_data", readburst_data, 96'hDDCCBBAA);
    chk("t1_read_low", avm_read, 96'h0);
    avm_readdatavalid = 1'b0;
    readburst_do = 1'b0;
    tick();
    chk("t1_pulse", readburst_done, 96'h0);
    chk("t1_hold", readburst_data, 96'hDDCCBBAA);

    // Misaligned three-dword read with one cycle of latency
    request(32'h2003, 2'd3, 4'd9);
    tick();
    chk("t2_addr", avm_address, 96'h800);
    chk("t2_bc", avm_burstcount, 96'h3);
    tick();
    chk("t2_read_low", avm_read, 96'h0);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h03020100;
    tick();
    avm_readdata = 32'h07060504;
    tick();
    chk("t2_done_early", readburst_done, 96'h0);
    avm_readdata = 32'h0B0A0908;
    tick();
    chk("t2_done", readburst_done, 96'h1);
    chk("t2_data", readburst_data, 96'h0000_000B_0A09_0807_0605_0403);
    avm_readdatavalid = 1'b0;
    readburst_do = 1'b0;
    tick();

    // Three cycles of waitrequest on a two-beat burst
    acc0 = acc_cnt;
    request(32'h40, 2'd2, 4'd8);
    avm_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3_read", avm_read, 96'h1);
      chk("t3_addr", avm_address, 96'h10);
      chk("t3_bc", avm_burstcount, 96'h2);
      tick();
    end
    chk("t3_read_last", avm_read, 96'h1);
    avm_waitrequest = 1'b0;
    tick();
    chk("t3_read_low", avm_read, 96'h0);
    avm_waitrequest = 1'b1;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h44332211;
    tick();
    chk("t3_done_early", readburst_done, 96'h0);
    avm_readdata = 32'h88776655;
    tick();
    chk("t3_done", readburst_done, 96'h1);
    chk("t3_data", readburst_data, 96'h0000_0000_8877_6655_4433_2211);
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    readburst_do = 1'b0;
    tick();
    chk("t3_accepts", acc_cnt - acc0, 96'h1);

    // Beats separated by four idle cycles
    acc0 = acc_cnt;
    done0 = done_cnt;
    request(32'h100, 2'd2, 4'd8);
    tick();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hA1A2A3A4;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      chk("t4_gap_done", readburst_done, 96'h0);
      chk("t4_gap_read", avm_read, 96'h0);
      tick();
    end
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hB1B2B3B4;
    tick();
    chk("t4_done", readburst_done, 96'h1);
    chk("t4_data", readburst_data, 96'h0000_0000_B1B2_B3B4_A1A2_A3A4);
    avm_readdatavalid = 1'b0;
    readburst_do = 1'b0;
    tick();
    chk("t4_done_count", done_cnt - done0, 96'h1);
    chk("t4_accepts", acc_cnt - acc0, 96'h1);

    // Stray readdatavalid in IDLE, then dword_length 0 with a byte offset
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDEADBEEF;
    tick();
    chk("t5_stray_done", readburst_done, 96'h0);
    chk("t5_stray_data", readburst_data, 96'h0000_0000_B1B2_B3B4_A1A2_A3A4);
    avm_readdatavalid = 1'b0;
    request(32'h11, 2'd0, 4'd2);
    tick();
    chk("t5_bc", avm_burstcount, 96'h1);
    chk("t5_addr", avm_address, 96'h4);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h12345678;
    tick();
    chk("t5_done", readburst_done, 96'h1);
    chk("t5_data", readburst_data, 96'h3456);
    avm_readdatavalid = 1'b0;
    readburst_do = 1'b0;
    tick();

    // Asynchronous reset in RECEIVE, late beats afterwards
    request(32'h0, 2'd3, 4'd12);
    tick();
    tick();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h55555555;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_done", readburst_done, 96'h0);
    chk("t6_rst_read", avm_read, 96'h0);
    chk("t6_rst_data", readburst_data, 96'h0);
    chk("t6_rst_addr", avm_address, 96'h0);
    chk("t6_rst_bc", avm_burstcount, 96'h0);
    readburst_do = 1'b0;
    avm_readdata = 32'h66666666;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_late_done", readburst_done, 96'h0);
    chk("t6_late_read", avm_read, 96'h0);
    chk("t6_late_data", readburst_data, 96'h0);
    avm_readdatavalid = 1'b0;
    tick();
    chk("t6_idle_done", readburst_done, 96'h0);
    request(32'h8, 2'd1, 4'd4);
    tick();
    chk("t6_read", avm_read, 96'h1);
    chk("t6_addr", avm_address, 96'h2);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hCAFEF00D;
    tick();
    chk("t6_done", readburst_done, 96'h1);
    chk("t6_data", readburst_data, 96'hCAFEF00D);

    // Back-to-back: do stays high through done and is taken as a new request
    request(32'h20, 2'd1, 4'd1);
    avm_readdatavalid = 1'b0;
    tick();
    chk("t7_idle_done", readburst_done, 96'h0);
    chk("t7_idle_read", avm_read, 96'h0);
    tick();
    chk("t7_read", avm_read, 96'h1);
    chk("t7_addr", avm_address, 96'h8);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h123456EE;
    tick();
    chk("t7_done", readburst_done, 96'h1);
    chk("t7_data", readburst_data, 96'hEE);
    avm_readdatavalid = 1'b0;
    readburst_do = 1'b0;
    tick();
    chk("t7_pulse", readburst_done, 96'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/readburst_avalon.md
# readburst_avalon

Memory-side responder for the readburst channel. Accepts a held request (address, dword count, byte count), issues one Avalon-MM burst read of up to three 32-bit words, and aligns the returned bytes into the 96-bit result. Returns the result with a one-cycle done pulse. Sits directly downstream of the readburst link stage, between it and the Avalon memory port.

## Interface
Parameters: none.

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- readburst_do  in  1  request valid; held high by upstream until done
- readburst_done  out  1  one-cycle completion pulse
- readburst_address  in  32  byte address of first requested byte
- readburst_dword_length  in  2  dwords to fetch; 1..3, 0 treated as 1
- readburst_byte_length  in  4  bytes requested, 1..12
- readburst_data  out  96  aligned result; byte 0 = byte at readburst_address
- avm_address  out  30  dword address (byte address [31:2])
- avm_read  out  1  Avalon read request
- avm_burstcount  out  3  burst length, 1..3
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  returned word
- avm_readdatavalid  in  1  returned word valid

## Operation
- Upstream guarantees address[1:0] + byte_length ≤ 4·dword_length ≤ 12.
- States: IDLE, ISSUE, RECEIVE, DONE.
- IDLE: on readburst_do=1, latch address[31:2], offset = address[1:0], byte_length, and count = (dword_length==0 ? 1 : dword_length); clear the word buffer and the beat counter; go to ISSUE.
- ISSUE: avm_read=1, avm_address = latched address, avm_burstcount = count. Hold all three stable while avm_waitrequest=1. On the cycle with avm_waitrequest=0, go to RECEIVE.
- RECEIVE: on each avm_readdatavalid=1, store avm_readdata into word slot beat (slot 0 = bits 31:0) and increment beat. On the beat where beat == count-1, go to DONE.
- Readdatavalid accepted in the ISSUE cycle where waitrequest=0 is also captured (zero-latency slave). If it is the last beat, go straight to DONE.
- DONE: readburst_done=1 for exactly one cycle. readburst_data = (128-bit buffer >> 8·offset) truncated to 96 bits, with bytes at index ≥ byte_length forced to 0. Return to IDLE.
- readburst_data is registered. It is held after DONE until the next request's DONE.
- avm_readdatavalid outside ISSUE/RECEIVE is ignored.
- readburst_do falling mid-transaction is ignored; the burst completes and done still pulses.
- Buffer is 4 words wide internally. Slot 3 is never written and stays 0.

## Timing
- Reset (async, immediate): state IDLE; avm_read=0, avm_address=0, avm_burstcount=0, readburst_done=0, readburst_data=0, internal buffer/counters 0.
- Reset mid-burst abandons the transfer. Any late readdatavalid after reset is ignored in IDLE.
- Request seen in IDLE at cycle T → avm_read=1 from T+1.
- With waitrequest=0 and data arriving L cycles after acceptance, done pulses one cycle after the last beat.
- Minimum request-to-done, for a zero-latency single beat: T+1 issue/capture → T+2 done.
- Back-to-back: in the cycle after done, do high is treated as a new request (IDLE accepts).
- avm_read is low in IDLE, RECEIVE and DONE. Only one burst is ever outstanding.

## Test plan
- Aligned single read: addr=0x1000, dword_length=1, byte_length=4, readdata 0xDDCCBBAA with zero wait → avm_address=0x400, burstcount=1; done 2 cycles after request; data[31:0]=0xDDCCBBAA, upper bits 0.
- Misaligned 3-dword read: addr=0x2003, dword_length=3, byte_length=9, words 0x03020100, 0x07060504, 0x0B0A0908 → data bytes 0..8 = 03,04,05,06,07,08,09,0A,0B; bytes 9..11 = 0.
- Waitrequest stall: waitrequest high 3 cycles with a 2-beat burst → address/burstcount/read stable throughout, one read accepted, done after the 2nd beat.
- Gapped beats: readdatavalid beats separated by 4 idle cycles → correct word order, single done pulse, no extra Avalon request.
- dword_length=0, byte_length=2, addr=0x11 → burstcount=1, data = readdata[23:8] zero-extended.
- Async reset asserted during RECEIVE, then a stray readdatavalid → all outputs 0 immediately, no done. A new request afterwards completes normally.
